// File: rtl/full_adder_pkg.sv
// Shared constants for the ripple-carry adder.
// The chain is one node longer than the operand to hold the carry-out.
package full_adder_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  function automatic int unsigned chain_len(input int unsigned w);
    return w + 1;
  endfunction

endpackage

// File: rtl/full_adder_fa_cell.sv
// Single-bit full adder cell; purely combinational.
// Chained by full_adder to form the ripple carry.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// Registered ripple-carry adder, one-cycle latency.
// Results hold while in_valid is low; out_valid pulses per operation.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int unsigned CL = chain_len(WIDTH);

  logic [CL-1:0]    c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c[i]),
      .sum (s[i]),
      .cout(c[i+1])
    );
  end

  // Reset wins over a same-cycle operation, which is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= s;
        cout <= c[WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench: WIDTH 1, 8 and 16 instances against an arithmetic model
// plus directed vectors with literal expected values.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1 = 0, b1 = 0, c1 = 0, v1 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       c8 = 0, v8 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        c16 = 0, v16 = 0;

  logic        s1, co1, ov1;
  logic [7:0]  s8;
  logic        co8, ov8;
  logic [15:0] s16;
  logic        co16, ov16;

  int n_chk  = 0;
  int n_fail = 0;
  bit started = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1),
    .in_valid(v1), .sum(s1), .cout(co1), .out_valid(ov1)
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8),
    .in_valid(v8), .sum(s8), .cout(co8), .out_valid(ov8)
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(c16),
    .in_valid(v16), .sum(s16), .cout(co16), .out_valid(ov16)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the total of the last accepted operation, cleared by reset.
  logic [1:0]  m1  = '0;
  logic [8:0]  m8  = '0;
  logic [16:0] m16 = '0;
  logic        mv1 = 0, mv8 = 0, mv16 = 0;

  always @(posedge clk) begin
    if (rst) begin
      m1 = '0; m8 = '0; m16 = '0;
      mv1 = 0; mv8 = 0; mv16 = 0;
    end else begin
      mv1  = v1;
      mv8  = v8;
      mv16 = v16;
      if (v1)  m1  = 2'(a1) + 2'(b1) + 2'(c1);
      if (v8)  m8  = 9'(a8) + 9'(b8) + 9'(c8);
      if (v16) m16 = 17'(a16) + 17'(b16) + 17'(c16);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("w1_model",  {ov1, co1, s1},     {mv1, m1});
      chk("w8_model",  {ov8, co8, s8},     {mv8, m8});
      chk("w16_model", {ov16, co16, s16},  {mv16, m16});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tab1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10,
                           2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    step;
    started = 1;
    step;
    chk("rst_w1",  {ov1, co1, s1},    '0);
    chk("rst_w8",  {ov8, co8, s8},    '0);
    chk("rst_w16", {ov16, co16, s16}, '0);

    rst = 0;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      v1 = 1;
      step;
      chk($sformatf("w1_vec%0d", i), {ov1, co1, s1}, {1'b1, tab1[i]});
    end
    v1 = 0;
    a1 = 1'bx;
    b1 = 1'bx;
    step;
    chk("w1_hold", {ov1, co1, s1}, 3'b011);

    a8 = 8'hFF; b8 = 8'h01; c8 = 1; v8 = 1;
    step;
    chk("w8_max_carry", {ov8, co8, s8}, {1'b1, 1'b1, 8'h01});
    a8 = 8'h3C; b8 = 8'h05; c8 = 0;
    step;
    chk("w8_3c_05", {ov8, co8, s8}, {1'b1, 1'b0, 8'h41});
    v8 = 0;
    for (int i = 0; i < 3; i++) begin
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      step;
      chk("w8_idle_hold", {ov8, co8, s8}, {1'b0, 1'b0, 8'h41});
    end

    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1; v16 = 1;
    step;
    chk("w16_all_ones", {ov16, co16, s16}, {1'b1, 1'b1, 16'hFFFF});
    a16 = 16'h1234; b16 = 16'h1111; c16 = 0;
    step;
    chk("w16_pre_rst", {ov16, co16, s16}, {1'b1, 1'b0, 16'h2345});

    rst = 1;
    a1 = 1; b1 = 1; c1 = 1; v1 = 1;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1; v8 = 1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1; v16 = 1;
    step;
    chk("rst_op_w1",  {ov1, co1, s1},    '0);
    chk("rst_op_w8",  {ov8, co8, s8},    '0);
    chk("rst_op_w16", {ov16, co16, s16}, '0);
    rst = 0;
    v1 = 0; v8 = 0; v16 = 0;
    step;
    chk("no_stale_w1",  ov1,  1'b0);
    chk("no_stale_w8",  ov8,  1'b0);
    chk("no_stale_w16", {ov16, co16, s16}, '0);

    a16 = 16'h0001; b16 = 16'h0002; c16 = 1; v16 = 1;
    step;
    chk("w16_after_rst", {ov16, co16, s16}, {1'b1, 1'b0, 16'h0004});

    for (int i = 0; i < 1000; i++) begin
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      step;
      chk("w16_stream_valid", ov16, 1'b1);
    end
    v16 = 0;
    step;
    chk("w16_stream_end", ov16, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
